// File: rtl/te_round_sequencer_pkg.sv
// te_pkg: shared constants and the FSM state type for the tracking-engine
// round sequencer and its watchdog.
//   TE_LANES       - correlator lanes per batch
//   TE_CHANNELS    - logical channels per round
//   TE_BATCH_W     - width of the batch counter (0..TE_MAX_BATCHES)
//   TE_MAX_BATCHES - batch-count saturation value
//   TE_WD_W        - watchdog counter width
package te_pkg;

  localparam int unsigned TE_LANES       = 4;
  localparam int unsigned TE_CHANNELS    = 32;
  localparam int unsigned TE_BATCH_W     = 4;
  localparam int unsigned TE_MAX_BATCHES = TE_CHANNELS / TE_LANES;
  localparam int unsigned TE_WD_W        = 16;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LATCH,
    S_FIND,
    S_WAIT_FIND,
    S_DISPATCH,
    S_WAIT_CORR,
    S_CLOSE,
    S_DONE
  } te_state_e;

endpackage

// File: rtl/te_round_sequencer_if.sv
// te_round_sequencer_if: handshake bundle between the round sequencer,
// find_channel and the 4-lane correlator.
//   master (sequencer): drives latch_enable_channel, start_find, te_over,
//                       corr_start, corr_lane_en; receives find_channel_done,
//                       channel_remain, physical_channel_en, corr_done.
//   slave  (find_channel + correlator side): the mirror image.
interface te_round_sequencer_if;
  import te_pkg::*;

  logic                   find_channel_done;
  logic [TE_CHANNELS-1:0] channel_remain;
  logic [TE_LANES-1:0]    physical_channel_en;
  logic                   corr_done;

  logic                   latch_enable_channel;
  logic                   start_find;
  logic                   te_over;
  logic                   corr_start;
  logic [TE_LANES-1:0]    corr_lane_en;

  modport master (
    input  find_channel_done, channel_remain, physical_channel_en, corr_done,
    output latch_enable_channel, start_find, te_over, corr_start, corr_lane_en
  );

  modport slave (
    output find_channel_done, channel_remain, physical_channel_en, corr_done,
    input  latch_enable_channel, start_find, te_over, corr_start, corr_lane_en
  );
endinterface

// File: rtl/te_watchdog.sv
// te_watchdog: correlator watchdog.
//   clk, rst - clock, synchronous active-high reset
//   clr      - zero the count (takes priority over en)
//   en       - count one cycle
//   expired  - combinational: en is high and the count has reached
//              CORR_TIMEOUT-1, i.e. this is the CORR_TIMEOUT-th enabled cycle
module te_watchdog import te_pkg::*; #(
  parameter int unsigned CORR_TIMEOUT = 4096
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam logic [TE_WD_W-1:0] TERM = TE_WD_W'(CORR_TIMEOUT - 1);

  logic [TE_WD_W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clr)     count_d = '0;
    else if (en) count_d = count_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) count_q <= '0;
    else     count_q <= count_d;
  end

  assign expired = en && (count_q == TERM);

endmodule

// File: rtl/te_round_sequencer.sv
// te_round_sequencer: runs one tracking-engine round over 32 channels in
// batches of up to 4 lanes (latch mask, then find / correlate / close).
//   clk, rst       - clock, synchronous active-high reset
//   round_trigger  - pulse: request a round (queued once if busy)
//   sw_abort       - pulse: abort the current round
//   status_clear   - clears overrun and timeout
//   te             - master side of te_round_sequencer_if
//   te_busy        - high outside IDLE
//   round_done     - pulse: round completed or aborted
//   batch_count    - batches dispatched in current/last round
//   overrun        - sticky: trigger dropped while one was already pending
//   timeout        - sticky: correlator watchdog fired
module te_round_sequencer import te_pkg::*; #(
  parameter int unsigned CORR_TIMEOUT = 4096
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  round_trigger,
  input  logic                  sw_abort,
  input  logic                  status_clear,
  te_round_sequencer_if.master  te,
  output logic                  te_busy,
  output logic                  round_done,
  output logic [TE_BATCH_W-1:0] batch_count,
  output logic                  overrun,
  output logic                  timeout
);

  te_state_e             state_q, state_d;
  logic                  pending_q, pending_d;
  logic                  abort_q, abort_d;
  logic                  overrun_q, overrun_d;
  logic                  timeout_q, timeout_d;
  logic                  timeout_set;
  logic [TE_BATCH_W-1:0] batch_q, batch_d;
  logic [TE_LANES-1:0]   lane_q, lane_d;
  logic                  latch_q, find_q, over_q, cstart_q, busy_q, rdone_q;
  logic                  wd_expired;

  te_watchdog #(.CORR_TIMEOUT(CORR_TIMEOUT)) u_watchdog (
    .clk     (clk),
    .rst     (rst),
    .clr     (state_q == S_DISPATCH),
    .en      (state_q == S_WAIT_CORR),
    .expired (wd_expired)
  );

  // Abort goes through CLOSE (te_over, lanes cleared) with abort_q forcing
  // CLOSE straight to DONE. Abort while already in CLOSE or DONE just lets
  // the round finish so te_over/round_done are never emitted twice.
  always_comb begin
    state_d     = state_q;
    abort_d     = abort_q;
    timeout_set = 1'b0;
    if (state_q != S_IDLE && sw_abort) begin
      abort_d = 1'b0;
      case (state_q)
        S_DONE:  state_d = S_IDLE;
        S_CLOSE: state_d = S_DONE;
        default: begin
          state_d = S_CLOSE;
          abort_d = 1'b1;
        end
      endcase
    end else begin
      case (state_q)
        S_IDLE:      if (round_trigger || pending_q) state_d = S_LATCH;
        S_LATCH:     state_d = S_FIND;
        S_FIND:      state_d = S_WAIT_FIND;
        S_WAIT_FIND: if (te.find_channel_done)
                       state_d = (te.physical_channel_en == '0) ? S_DONE : S_DISPATCH;
        S_DISPATCH:  state_d = S_WAIT_CORR;
        S_WAIT_CORR: begin
          if (te.corr_done) begin
            state_d = S_CLOSE;
          end else if (wd_expired) begin
            state_d     = S_CLOSE;
            timeout_set = 1'b1;
          end
        end
        S_CLOSE: begin
          abort_d = 1'b0;
          state_d = (abort_q || te.channel_remain == '0) ? S_DONE : S_FIND;
        end
        S_DONE:      state_d = S_IDLE;
        default:     state_d = S_IDLE;
      endcase
    end
  end

  always_comb begin
    pending_d = pending_q;
    if (state_q == S_IDLE)   pending_d = 1'b0;
    else if (sw_abort)       pending_d = 1'b0;
    else if (round_trigger)  pending_d = 1'b1;

    overrun_d = status_clear ? 1'b0 : (overrun_q | (round_trigger & pending_q));
    timeout_d = status_clear ? 1'b0 : (timeout_q | timeout_set);

    batch_d = batch_q;
    if (state_d == S_LATCH)
      batch_d = '0;
    else if (state_d == S_DISPATCH && batch_q != TE_BATCH_W'(TE_MAX_BATCHES))
      batch_d = batch_q + 1'b1;

    lane_d = lane_q;
    if (state_d == S_DISPATCH)   lane_d = te.physical_channel_en;
    else if (state_d == S_CLOSE) lane_d = '0;
  end

  // Outputs are registered from the next-state decode, so each one is high
  // exactly while state_q holds the matching state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      pending_q <= 1'b0;
      abort_q   <= 1'b0;
      overrun_q <= 1'b0;
      timeout_q <= 1'b0;
      batch_q   <= '0;
      lane_q    <= '0;
      latch_q   <= 1'b0;
      find_q    <= 1'b0;
      over_q    <= 1'b0;
      cstart_q  <= 1'b0;
      busy_q    <= 1'b0;
      rdone_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      abort_q   <= abort_d;
      overrun_q <= overrun_d;
      timeout_q <= timeout_d;
      batch_q   <= batch_d;
      lane_q    <= lane_d;
      latch_q   <= (state_d == S_LATCH);
      find_q    <= (state_d == S_FIND);
      over_q    <= (state_d == S_CLOSE);
      cstart_q  <= (state_d == S_DISPATCH);
      busy_q    <= (state_d != S_IDLE);
      rdone_q   <= (state_d == S_DONE);
    end
  end

  assign te.latch_enable_channel = latch_q;
  assign te.start_find           = find_q;
  assign te.te_over              = over_q;
  assign te.corr_start           = cstart_q;
  assign te.corr_lane_en         = lane_q;
  assign te_busy                 = busy_q;
  assign round_done              = rdone_q;
  assign batch_count             = batch_q;
  assign overrun                 = overrun_q;
  assign timeout                 = timeout_q;

endmodule

// File: tb/tb_te_round_sequencer.sv
module tb_te_round_sequencer;
  import te_pkg::*;

  logic clk = 1'b0;
  logic rst, round_trigger, sw_abort, status_clear;
  logic te_busy, round_done, overrun, timeout;
  logic [3:0] batch_count;

  te_round_sequencer_if ifc ();

  te_round_sequencer #(.CORR_TIMEOUT(16)) dut (
    .clk           (clk),
    .rst           (rst),
    .round_trigger (round_trigger),
    .sw_abort      (sw_abort),
    .status_clear  (status_clear),
    .te            (ifc),
    .te_busy       (te_busy),
    .round_done    (round_done),
    .batch_count   (batch_count),
    .overrun       (overrun),
    .timeout       (timeout)
  );

  always #5 clk = ~clk;

  // ---------------- find_channel / correlator model ----------------
  logic [31:0] mask = '0;
  int          corr_delay = 0;   // 0: correlator never answers

  logic [31:0] remain_m, stage_rem;
  logic [3:0]  pen_m, stage_pen;
  logic        done_m, corr_m;
  int          fcnt, ccnt;

  function automatic void pick(input logic [31:0] r, output logic [3:0] p,
                               output logic [31:0] nr, output int n);
    n  = 0;
    nr = r;
    for (int i = 0; i < 32; i++)
      if (nr[i] && n < 4) begin
        nr[i] = 1'b0;
        n++;
      end
    p = 4'((1 << n) - 1);
  endfunction

  always @(posedge clk) begin : model
    logic [3:0]  p_v;
    logic [31:0] nr_v;
    int          n_v;
    if (rst) begin
      remain_m <= '0; pen_m <= '0; done_m <= 1'b0; corr_m <= 1'b0;
      fcnt <= 0; ccnt <= 0; stage_pen <= '0; stage_rem <= '0;
    end else begin
      corr_m <= 1'b0;
      if (ifc.latch_enable_channel) remain_m <= mask;
      if (ifc.start_find) begin
        pick(remain_m, p_v, nr_v, n_v);
        stage_pen <= p_v;
        stage_rem <= nr_v;
        done_m    <= 1'b0;
        fcnt      <= 3 * n_v + 1;
      end else if (fcnt != 0) begin
        fcnt <= fcnt - 1;
        if (fcnt == 1) begin
          done_m   <= 1'b1;
          pen_m    <= stage_pen;
          remain_m <= stage_rem;
        end
      end
      if (ifc.te_over) pen_m <= '0;
      if (ifc.corr_start && corr_delay > 0) ccnt <= corr_delay;
      else if (ccnt != 0) begin
        ccnt <= ccnt - 1;
        if (ccnt == 1) corr_m <= 1'b1;
      end
    end
  end

  assign ifc.find_channel_done   = done_m;
  assign ifc.channel_remain      = remain_m;
  assign ifc.physical_channel_en = pen_m;
  assign ifc.corr_done           = corr_m;

  // ---------------- pulse monitor ----------------
  int n_cs = 0, n_to = 0, n_le = 0, n_rd = 0;
  logic [3:0] lane_log [0:63];

  always @(negedge clk) begin
    if (ifc.corr_start) begin
      if (n_cs < 64) lane_log[n_cs] = ifc.corr_lane_en;
      n_cs++;
    end
    if (ifc.te_over)              n_to++;
    if (ifc.latch_enable_channel) n_le++;
    if (round_done)               n_rd++;
  end

  // ---------------- checking ----------------
  int n_err = 0, n_checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic pulse(input int sel);
    @(negedge clk);
    case (sel)
      0: round_trigger = 1'b1;
      1: sw_abort      = 1'b1;
      default: status_clear = 1'b1;
    endcase
    @(negedge clk);
    round_trigger = 1'b0;
    sw_abort      = 1'b0;
    status_clear  = 1'b0;
  endtask

  // sel 0: round_done, 1: corr_start
  task automatic wait_for(input int sel, input int maxc, input string name);
    bit ok = 0;
    for (int i = 0; i < maxc; i++) begin
      @(negedge clk);
      if ((sel == 0 && round_done) || (sel == 1 && ifc.corr_start)) begin
        ok = 1;
        break;
      end
    end
    check(name, 32'(ok), 32'd1);
  endtask

  typedef struct {
    logic [31:0] mask;
    int          delay;
    int          batches;
    logic [3:0]  first_lane;
    logic [3:0]  last_lane;
  } vec_t;

  vec_t vecs [5];

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int cs0, to0, le0, rd0, cnt;

    vecs[0] = '{32'h0000_000F, 10, 1, 4'hF, 4'hF};
    vecs[1] = '{32'hFFFF_FFFF,  3, 8, 4'hF, 4'hF};
    vecs[2] = '{32'h8000_0021,  2, 1, 4'h7, 4'h7};
    vecs[3] = '{32'h0000_0000,  2, 0, 4'h0, 4'h0};
    vecs[4] = '{32'h0001_003F,  4, 2, 4'hF, 4'h7};

    rst = 1'b1; round_trigger = 1'b0; sw_abort = 1'b0; status_clear = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_outputs",
          {ifc.latch_enable_channel, ifc.start_find, ifc.te_over, ifc.corr_start,
           ifc.corr_lane_en, te_busy, round_done, batch_count, overrun, timeout}, '0);
    rst = 1'b0;
    @(negedge clk);

    // ---- table-driven rounds ----
    for (int v = 0; v < 5; v++) begin
      mask       = vecs[v].mask;
      corr_delay = vecs[v].delay;
      cs0 = n_cs; to0 = n_to;
      pulse(0);
      wait_for(0, 2000, $sformatf("v%0d_round_done", v));
      check($sformatf("v%0d_batch_count", v), 32'(batch_count), 32'(vecs[v].batches));
      check($sformatf("v%0d_remain_at_done", v), ifc.channel_remain, '0);
      @(negedge clk);
      check($sformatf("v%0d_busy_after", v), 32'(te_busy), 32'd0);
      check($sformatf("v%0d_corr_starts", v), 32'(n_cs - cs0), 32'(vecs[v].batches));
      check($sformatf("v%0d_te_overs", v), 32'(n_to - to0), 32'(vecs[v].batches));
      check($sformatf("v%0d_first_lane", v),
            32'((n_cs > cs0) ? lane_log[cs0] : 4'h0), 32'(vecs[v].first_lane));
      check($sformatf("v%0d_last_lane", v),
            32'((n_cs > cs0) ? lane_log[n_cs-1] : 4'h0), 32'(vecs[v].last_lane));
    end

    // ---- empty mask latency: trigger to round_done ----
    mask = '0;
    @(negedge clk);
    round_trigger = 1'b1;
    cnt = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      round_trigger = 1'b0;
      cnt++;
      if (round_done) break;
    end
    check("empty_latency", 32'(cnt), 32'd5);
    repeat (2) @(negedge clk);

    // ---- watchdog timeout, round continues, status_clear ----
    mask = 32'h0000_00FF; corr_delay = 0;
    pulse(0);
    wait_for(1, 200, "to_corr_start");
    repeat (16) @(negedge clk);
    check("to_no_over_before", {ifc.te_over, timeout}, '0);
    @(negedge clk);
    check("to_over_at_limit", 32'(ifc.te_over), 32'd1);
    check("to_timeout_set", 32'(timeout), 32'd1);
    wait_for(0, 500, "to_round_done");
    check("to_batch_count", 32'(batch_count), 32'd2);
    pulse(2);
    check("to_status_clear", 32'(timeout), 32'd0);

    // ---- pending trigger and overrun ----
    mask = 32'h0000_000F; corr_delay = 10;
    le0 = n_le; rd0 = n_rd;
    pulse(0);
    repeat (3) @(negedge clk);
    pulse(0);
    check("ov_first_extra", 32'(overrun), 32'd0);
    pulse(0);
    check("ov_second_extra", 32'(overrun), 32'd1);
    wait_for(0, 500, "ov_round1_done");
    wait_for(0, 500, "ov_round2_done");
    repeat (40) @(negedge clk);
    check("ov_latch_count", 32'(n_le - le0), 32'd2);
    check("ov_round_count", 32'(n_rd - rd0), 32'd2);
    check("ov_idle", 32'(te_busy), 32'd0);
    pulse(2);
    check("ov_cleared", 32'(overrun), 32'd0);

    // ---- abort in WAIT_CORR with a pending trigger ----
    mask = 32'h0000_00FF; corr_delay = 0;
    pulse(0);
    wait_for(1, 200, "ab_corr_start");
    le0 = n_le;
    repeat (2) @(negedge clk);
    pulse(0);
    @(negedge clk);
    sw_abort = 1'b1;
    @(negedge clk);
    sw_abort = 1'b0;
    check("ab_te_over", 32'(ifc.te_over), 32'd1);
    check("ab_lanes_clear", 32'(ifc.corr_lane_en), 32'd0);
    check("ab_batch_count", 32'(batch_count), 32'd1);
    @(negedge clk);
    check("ab_round_done", 32'(round_done), 32'd1);
    @(negedge clk);
    check("ab_busy_low", 32'(te_busy), 32'd0);
    repeat (20) @(negedge clk);
    check("ab_no_restart", 32'(n_le - le0), 32'd0);

    // ---- reset mid-round ----
    mask = 32'h0000_000F; corr_delay = 0;
    pulse(0);
    wait_for(1, 200, "rs_corr_start");
    repeat (2) @(negedge clk);
    to0 = n_to;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("rs_idle", {te_busy, ifc.te_over, ifc.corr_lane_en}, '0);
    repeat (3) @(negedge clk);
    check("rs_no_te_over", 32'(n_to - to0), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/te_round_sequencer.md
# te_round_sequencer

Sequences one tracking-engine round over the 32 logical channels. On a round trigger it latches the enable mask into `find_channel`, then repeats batches of up to 4 channels: find, correlate, close. It drives the `find_channel` controls (`latch_enable_channel`, `start_find`, `te_over`) and handshakes with the 4-lane correlator. It also provides round-level status (busy, done pulse, batch count, overrun, timeout) to the TE register block.

## Interface
- `CORR_TIMEOUT`, default 4096: max cycles in WAIT_CORR before forced close; legal range 2..65535.
- `clk`  in  1  system clock
- `rst`  in  1  synchronous active-high reset; one clock, and reset is synchronous and active-high
- `round_trigger`  in  1  single-cycle pulse requesting a round
- `sw_abort`  in  1  single-cycle pulse aborting the current round
- `status_clear`  in  1  clears `overrun` and `timeout`
- `find_channel_done`  in  1  from `find_channel`; combinational, high while its search has ended
- `channel_remain`  in  32  from `find_channel`; channels not yet dispatched
- `physical_channel_en`  in  4  from `find_channel`; lanes filled in this batch
- `corr_done`  in  1  single-cycle pulse: correlator finished the current batch
- `latch_enable_channel`  out  1  pulse: load `te_channel_enable` into `channel_remain`
- `start_find`  out  1  pulse: begin a 4-lane search
- `te_over`  out  1  pulse: close the batch and clear lane enables
- `corr_start`  out  1  pulse: launch correlator on `corr_lane_en`
- `corr_lane_en`  out  4  registered copy of `physical_channel_en` taken at dispatch
- `te_busy`  out  1  high in every state except IDLE
- `round_done`  out  1  pulse: round completed or aborted
- `batch_count`  out  4  batches dispatched in the current or last round (0..8)
- `overrun`  out  1  sticky: trigger arrived while a trigger was already pending
- `timeout`  out  1  sticky: WAIT_CORR exceeded `CORR_TIMEOUT`

## Operation
- States: IDLE, LATCH, FIND, WAIT_FIND, DISPATCH, WAIT_CORR, CLOSE, DONE.
- IDLE -> LATCH on `round_trigger` or `pending`.
- LATCH: `latch_enable_channel`=1; clear `batch_count`; -> FIND.
- FIND: `start_find`=1; -> WAIT_FIND.
- WAIT_FIND: wait for `find_channel_done`.
  - If `physical_channel_en`==0, go to DONE.
  - Otherwise go to DISPATCH.
- DISPATCH: `corr_start`=1; `corr_lane_en`<=`physical_channel_en`; `batch_count`+=1 (saturates at 8); clear watchdog; -> WAIT_CORR.
- WAIT_CORR: go to CLOSE on `corr_done`. If the watchdog reaches `CORR_TIMEOUT`, set `timeout` and go to CLOSE.
- CLOSE: `te_over`=1; `corr_lane_en`<=0.
  - If `channel_remain`!=0, go to FIND.
  - Otherwise go to DONE.
- DONE: `round_done`=1; -> IDLE.
- Pending trigger: 1-bit `pending` is set by `round_trigger` while not in IDLE. A second trigger while `pending`=1 sets `overrun`; that trigger is dropped. IDLE consumes `pending`.
- Abort: `sw_abort` in any non-IDLE state forces CLOSE-like cleanup. `te_over`=1 and `corr_lane_en`<=0 in the next cycle, then DONE. `pending` is cleared. `sw_abort` in IDLE is ignored.
- `status_clear` has priority over a same-cycle set, so a same-cycle set is lost.
- `corr_done` outside WAIT_CORR is ignored.

## Timing
- All outputs are registered Moore decodes of state. Every output resets to 0, `batch_count` included; the state resets to IDLE; `pending` resets to 0.
- Cycle 0: trigger. Cycle 1: LATCH. Cycle 2: FIND (`start_find`). Cycle 3: WAIT_FIND.
- `find_channel` needs 3 cycles per found lane plus 1. So a full 4-lane batch reaches done about 14 cycles after `start_find`.
- WAIT_FIND samples `find_channel_done` and `physical_channel_en` in the same cycle.
- CLOSE to the next `start_find` is 1 cycle.
- An empty enable mask gives `round_done` about 5 cycles after the trigger, with `batch_count`=0.
- Watchdog: 16-bit counter, cleared in DISPATCH, increments each WAIT_CORR cycle. Timeout fires when the count equals `CORR_TIMEOUT`-1.
- Reset mid-round: returns to IDLE the next cycle with no `te_over` emitted. The TE is also reset by the same `rst`.

## Structure
- Shared package `te_pkg`: state encoding localparams, `TE_LANES`=4, `TE_CHANNELS`=32, batch-count width.
- One sub-module `te_watchdog`: clear, enable, terminal-count compare, parameterised by `CORR_TIMEOUT`.

## Test plan
- Enable mask 0x0000_000F; `corr_done` 10 cycles after `corr_start` -> one batch with `corr_lane_en`=4'hF, `batch_count`=1, one `te_over`, then `round_done`.
- Enable mask 0xFFFF_FFFF -> 8 batches, each `corr_lane_en`=4'hF, `batch_count`=8, `channel_remain`=0 at DONE.
- Enable mask 0x8000_0001 plus bit 5 -> one batch with `corr_lane_en`=4'h7. Enable mask 0 -> `round_done` with no `corr_start`.
- `CORR_TIMEOUT`=16 and `corr_done` never arrives -> `timeout`=1 after 16 WAIT_CORR cycles, CLOSE follows, and the round continues. `status_clear` then clears `timeout`.
- Two triggers during a round -> `pending` set and `overrun`=1. After `round_done`, exactly one new round starts.
- `sw_abort` in WAIT_CORR -> `te_over` next cycle, then `round_done`, `pending` cleared, `te_busy`=0.
